// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cu_pkg
// Description : Shared opcodes, FSM states and control encodings for the
//               control_unit slice.
// Revision    : 1.0 - initial release
// ============================================================================
package cu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDR = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_REG = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  typedef struct packed {
    logic       load_acc;
    logic       reg_write;
    logic [1:0] sel_acc;
    logic [1:0] alu_op;
    logic [3:0] imm;
    logic [1:0] reg_addr;
    logic       jump;
    logic       halt;
    logic       illegal;
  } cu_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/cu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cu_decoder
// Description : Combinational opcode-to-control decode; all zero unless en.
// Revision    : 1.0 - initial release
// ============================================================================
module cu_decoder
  import cu_pkg::*;
(
  input  logic       en,
  input  logic [7:0] ir,
  input  logic       zero,
  output cu_ctrl_t   ctrl
);

  logic [3:0] w_opcode;
  logic [3:0] w_operand;

  assign w_opcode  = ir[7:4];
  assign w_operand = ir[3:0];

  always_comb begin
    ctrl = '0;
    if (en) begin
      case (w_opcode)
        OP_NOP: ;
        OP_LDI: begin
          ctrl.load_acc = 1'b1;
          ctrl.sel_acc  = SEL_IMM;
          ctrl.imm      = w_operand;
        end
        OP_LDR: begin
          ctrl.load_acc = 1'b1;
          ctrl.sel_acc  = SEL_REG;
          ctrl.reg_addr = w_operand[1:0];
        end
        OP_STR: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_addr  = w_operand[1:0];
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
          ctrl.load_acc = 1'b1;
          ctrl.sel_acc  = SEL_ALU;
          ctrl.alu_op   = w_opcode[1:0];
          ctrl.reg_addr = w_operand[1:0];
        end
        OP_JMP: ctrl.jump = 1'b1;
        OP_JZ:  ctrl.jump = zero;
        OP_HLT: ctrl.halt = 1'b1;
        // 0xA-0xE execute as NOP but are flagged
        default: ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Fetch/decode/execute sequencer with pc, IR and sticky illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
  import cu_pkg::*;
(
  input  logic       clk,
  input  logic       CLR,
  input  logic       run,
  input  logic [7:0] instr,
  input  logic       zero,
  output logic [7:0] pc,
  output logic       mem_rd,
  output logic       LoadAcc,
  output logic [1:0] SelAcc,
  output logic [3:0] imm,
  output logic [1:0] alu_op,
  output logic [1:0] reg_addr,
  output logic       RegWrite,
  output logic       halted,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_pc;
  logic [7:0] r_ir;
  logic       r_illegal;
  logic       w_in_exec;
  cu_ctrl_t   w_ctrl;

  assign w_in_exec = (r_state == ST_EXECUTE);

  cu_decoder u_decoder (
    .en   (w_in_exec),
    .ir   (r_ir),
    .zero (zero),
    .ctrl (w_ctrl)
  );

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (run) w_next_state = ST_FETCH;
      ST_FETCH:   w_next_state = ST_DECODE;
      ST_DECODE:  w_next_state = ST_EXECUTE;
      ST_EXECUTE: w_next_state = w_ctrl.halt ? ST_HALT : ST_FETCH;
      ST_HALT:    w_next_state = ST_HALT;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // pc moves only when EXECUTE retires; jumps keep the upper nibble (page)
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      r_pc      <= 8'h00;
      r_ir      <= 8'h00;
      r_illegal <= 1'b0;
    end else begin
      if (r_state == ST_DECODE) begin
        r_ir <= instr;
      end
      if (w_in_exec && !w_ctrl.halt) begin
        r_pc <= w_ctrl.jump ? {r_pc[7:4], r_ir[3:0]} : r_pc + 8'd1;
      end
      if (w_in_exec && w_ctrl.illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Strobes decode from state so an async reset removes them at once
  assign pc       = r_pc;
  assign mem_rd   = (r_state == ST_FETCH);
  assign LoadAcc  = w_ctrl.load_acc;
  assign SelAcc   = w_ctrl.sel_acc;
  assign imm      = w_ctrl.imm;
  assign alu_op   = w_ctrl.alu_op;
  assign reg_addr = w_ctrl.reg_addr;
  assign RegWrite = w_ctrl.reg_write;
  assign halted   = (r_state == ST_HALT);
  assign illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Scoreboard bench for control_unit with directed programs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  logic       clk = 1'b0;
  logic       CLR;
  logic       run;
  logic [7:0] instr;
  logic       zero;
  logic [7:0] pc;
  logic       mem_rd;
  logic       LoadAcc;
  logic [1:0] SelAcc;
  logic [3:0] imm;
  logic [1:0] alu_op;
  logic [1:0] reg_addr;
  logic       RegWrite;
  logic       halted;
  logic       illegal;

  control_unit dut (
    .clk      (clk),
    .CLR      (CLR),
    .run      (run),
    .instr    (instr),
    .zero     (zero),
    .pc       (pc),
    .mem_rd   (mem_rd),
    .LoadAcc  (LoadAcc),
    .SelAcc   (SelAcc),
    .imm      (imm),
    .alu_op   (alu_op),
    .reg_addr (reg_addr),
    .RegWrite (RegWrite),
    .halted   (halted),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  logic [7:0] prog [256];
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Program memory: data returned during the cycle after mem_rd
  always @(negedge clk) if (mem_rd === 1'b1) instr = prog[pc];

  typedef struct {
    int         cyc;
    bit         fetch;
    logic [7:0] pc;
    bit         ld;
    bit         wr;
    logic [1:0] sel;
    logic [3:0] imm;
    logic [1:0] alu;
    logic [1:0] ra;
  } exp_t;

  exp_t exp_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void exp_fetch(int c, logic [7:0] p);
    exp_q.push_back('{cyc: c, fetch: 1'b1, pc: p, ld: 1'b0, wr: 1'b0,
                      sel: 2'b00, imm: 4'h0, alu: 2'b00, ra: 2'b00});
  endfunction

  function automatic void exp_exec(int c, bit ld, bit wr, logic [1:0] sel,
                                   logic [3:0] im, logic [1:0] alu, logic [1:0] ra);
    exp_q.push_back('{cyc: c, fetch: 1'b0, pc: 8'h00, ld: ld, wr: wr,
                      sel: sel, imm: im, alu: alu, ra: ra});
  endfunction

  // Monitor: every strobe must match the next queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (CLR === 1'b0) begin
      if (mem_rd !== 1'b0 || LoadAcc !== 1'b0 || RegWrite !== 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_strobe: got mem_rd=%b LoadAcc=%b RegWrite=%b pc=%0h, expected none (cycle %0d)",
                   mem_rd, LoadAcc, RegWrite, pc, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("mem_rd", {31'd0, mem_rd}, {31'd0, e.fetch});
          if (e.fetch) chk("fetch_pc", {24'd0, pc}, {24'd0, e.pc});
          chk("LoadAcc", {31'd0, LoadAcc}, {31'd0, e.ld});
          chk("RegWrite", {31'd0, RegWrite}, {31'd0, e.wr});
          chk("SelAcc", {30'd0, SelAcc}, {30'd0, e.sel});
          chk("imm", {28'd0, imm}, {28'd0, e.imm});
          chk("alu_op", {30'd0, alu_op}, {30'd0, e.alu});
          chk("reg_addr", {30'd0, reg_addr}, {30'd0, e.ra});
        end
      end else begin
        chk("quiet_ctrl", {22'd0, SelAcc, alu_op, reg_addr, imm}, 32'd0);
      end
    end
  end

  task automatic to_cycle(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drained(string tag);
    chk({tag, "_queue_drained"}, exp_q.size(), 32'd0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge
  task automatic do_reset();
    #2;
    CLR = 1'b1;
    run = 1'b0;
    #1;
    chk("rst_pc", {24'd0, pc}, 32'h00);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_LoadAcc", {31'd0, LoadAcc}, 32'd0);
    chk("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
    @(negedge clk);
    CLR  = 1'b0;
    zero = 1'b0;
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
  endtask

  task automatic run_jz(bit z, logic [7:0] target);
    int b;
    prog[8'h23] = 8'h97;
    prog[8'h24] = 8'hF0;
    prog[8'h27] = 8'hF0;
    zero = z;
    run  = 1'b1;
    b    = cyc;
    for (int k = 0; k <= 8'h23; k++) exp_fetch(b + 1 + 3 * k, 8'(k));
    exp_fetch(b + 1 + 3 * 36, target);
    to_cycle(b + 4 + 3 * 36);
    chk("jz_halted", {31'd0, halted}, 32'd1);
    chk("jz_pc", {24'd0, pc}, {24'd0, target});
    drained("jz");
    do_reset();
  endtask

  initial begin
    int b;
    int idx;
    CLR   = 1'b1;
    run   = 1'b0;
    zero  = 1'b0;
    instr = 8'h00;
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    @(negedge clk);
    chk("init_pc", {24'd0, pc}, 32'h00);
    chk("init_halted", {31'd0, halted}, 32'd0);
    chk("init_mem_rd", {31'd0, mem_rd}, 32'd0);
    @(negedge clk);
    CLR = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_pc", {24'd0, pc}, 32'h00);

    // LDI 5 ; HLT
    prog[0] = 8'h15;
    prog[1] = 8'hF0;
    run = 1'b1;
    b   = cyc;
    exp_fetch(b + 1, 8'h00);
    exp_exec(b + 3, 1'b1, 1'b0, 2'b01, 4'h5, 2'b00, 2'b00);
    exp_fetch(b + 4, 8'h01);
    to_cycle(b + 6);
    chk("a_halted_in_exec", {31'd0, halted}, 32'd0);
    to_cycle(b + 7);
    chk("a_halted", {31'd0, halted}, 32'd1);
    chk("a_pc", {24'd0, pc}, 32'h01);
    repeat (6) @(negedge clk);
    chk("a_halt_hold_pc", {24'd0, pc}, 32'h01);
    chk("a_halt_hold", {31'd0, halted}, 32'd1);
    drained("a");
    do_reset();

    // ADD r2; STR r1; SUB r3; AND r1; OR r0; LDR r2; HLT  with a one-cycle run pulse
    prog[0] = 8'h42; prog[1] = 8'h31; prog[2] = 8'h53; prog[3] = 8'h61;
    prog[4] = 8'h70; prog[5] = 8'h2E; prog[6] = 8'hF0;
    run = 1'b1;
    b   = cyc;
    exp_fetch(b + 1, 8'h00);
    exp_exec(b + 3, 1'b1, 1'b0, 2'b00, 4'h0, 2'b00, 2'd2);
    exp_fetch(b + 4, 8'h01);
    exp_exec(b + 6, 1'b0, 1'b1, 2'b00, 4'h0, 2'b00, 2'd1);
    exp_fetch(b + 7, 8'h02);
    exp_exec(b + 9, 1'b1, 1'b0, 2'b00, 4'h0, 2'b01, 2'd3);
    exp_fetch(b + 10, 8'h03);
    exp_exec(b + 12, 1'b1, 1'b0, 2'b00, 4'h0, 2'b10, 2'd1);
    exp_fetch(b + 13, 8'h04);
    exp_exec(b + 15, 1'b1, 1'b0, 2'b00, 4'h0, 2'b11, 2'd0);
    exp_fetch(b + 16, 8'h05);
    exp_exec(b + 18, 1'b1, 1'b0, 2'b10, 4'h0, 2'b00, 2'd2);
    exp_fetch(b + 19, 8'h06);
    @(negedge clk);
    run = 1'b0;
    to_cycle(b + 22);
    chk("b_halted", {31'd0, halted}, 32'd1);
    chk("b_pc", {24'd0, pc}, 32'h06);
    drained("b");
    do_reset();

    // JZ 7 at 0x23: taken and not taken
    run_jz(1'b1, 8'h27);
    run_jz(1'b0, 8'h24);

    // Illegal opcode at 0x00, in-page JMP at 0x10, then pc wraps 0xFF -> 0x00
    prog[8'h00] = 8'hB0;
    prog[8'h10] = 8'h8C;
    run = 1'b1;
    b   = cyc;
    idx = 0;
    for (int p = 8'h00; p <= 8'h10; p++) begin
      exp_fetch(b + 1 + 3 * idx, 8'(p));
      idx++;
    end
    for (int p = 8'h1C; p <= 8'hFF; p++) begin
      exp_fetch(b + 1 + 3 * idx, 8'(p));
      idx++;
    end
    exp_fetch(b + 1 + 3 * idx, 8'h00);
    to_cycle(b + 4);
    chk("d_illegal_set", {31'd0, illegal}, 32'd1);
    chk("d_continues_pc", {24'd0, pc}, 32'h01);
    prog[8'h00] = 8'hF0;
    to_cycle(b + 4 + 3 * idx);
    chk("d_wrap_halted", {31'd0, halted}, 32'd1);
    chk("d_wrap_pc", {24'd0, pc}, 32'h00);
    chk("d_illegal_sticky", {31'd0, illegal}, 32'd1);
    drained("d");
    do_reset();

    // Reset during EXECUTE of LDI at pc=1
    prog[0] = 8'h00;
    prog[1] = 8'h1A;
    prog[2] = 8'hF0;
    run = 1'b1;
    b   = cyc;
    exp_fetch(b + 1, 8'h00);
    exp_fetch(b + 4, 8'h01);
    exp_exec(b + 6, 1'b1, 1'b0, 2'b01, 4'hA, 2'b00, 2'b00);
    to_cycle(b + 6);
    #2;
    CLR = 1'b1;
    run = 1'b0;
    #1;
    chk("e_LoadAcc_drop", {31'd0, LoadAcc}, 32'd0);
    chk("e_SelAcc_drop", {30'd0, SelAcc}, 32'd0);
    chk("e_pc_cleared", {24'd0, pc}, 32'h00);
    @(negedge clk);
    CLR = 1'b0;
    repeat (5) @(negedge clk);
    chk("e_idle_pc", {24'd0, pc}, 32'h00);
    chk("e_idle_halted", {31'd0, halted}, 32'd0);
    drained("e_pre");
    run = 1'b1;
    b   = cyc;
    exp_fetch(b + 1, 8'h00);
    exp_fetch(b + 4, 8'h01);
    exp_exec(b + 6, 1'b1, 1'b0, 2'b01, 4'hA, 2'b00, 2'b00);
    exp_fetch(b + 7, 8'h02);
    to_cycle(b + 10);
    chk("e_halted", {31'd0, halted}, 32'd1);
    chk("e_pc", {24'd0, pc}, 32'h02);
    drained("e");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
